// File: rtl/midi_sysid_pkg.sv
// midi_sysid_pkg: shared types and constants for the system-ID arbiter.
`default_nettype none

package midi_sysid_pkg;

  typedef enum logic [1:0] {
    BOOT_ID = 2'd0,
    BOOT_TS = 2'd1,
    CHECK   = 2'd2,
    RUN     = 2'd3
  } sysid_state_t;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  localparam logic [31:0] DEFAULT_EXPECTED_ID = 32'd0;
  localparam logic [31:0] DEFAULT_EXPECTED_TS = 32'd1424903334;

endpackage

`default_nettype wire

// File: rtl/midi_rr_arbiter.sv
// midi_rr_arbiter: N-way round-robin arbiter with one-hot grant and winner index.
`default_nettype none

module midi_rr_arbiter
  import midi_sysid_pkg::*;
#(
  parameter int N = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [N-1:0]         req,
  input  logic                 enable,
  output logic [N-1:0]         gnt,
  output logic                 granted,
  output logic [$clog2(N)-1:0] winner
);

  localparam int IW = $clog2(N);

  logic [IW-1:0] last_winner;
  logic          found;
  int            idx;

  // Search begins one past the previous winner so every requester gets a turn.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int k = 1; k <= N; k++) begin
      idx = int'(last_winner) + k;
      if (idx >= N) idx = idx - N;
      if (!found && req[IW'(idx)]) begin
        found  = 1'b1;
        winner = IW'(idx);
      end
    end
  end

  assign granted = enable & found;
  assign gnt     = granted ? ({{(N-1){1'b0}}, 1'b1} << winner) : '0;

  always_ff @(posedge clock) begin
    if (reset) begin
      last_winner <= IW'(N - 1);
    end else if (granted) begin
      last_winner <= winner;
    end
  end

endmodule

`default_nettype wire

// File: rtl/midi_sysid_arbiter.sv
// midi_sysid_arbiter: boot self-check of the system-ID slave, then round-robin requester reads.
// Optional periodic re-check enabled by defining MIDI_SYSID_RECHECK_EN.
`default_nettype none

module midi_sysid_arbiter
  import midi_sysid_pkg::*;
#(
  parameter int          NUM_REQ        = 2,
  parameter logic [31:0] EXPECTED_ID    = DEFAULT_EXPECTED_ID,
  parameter logic [31:0] EXPECTED_TS    = DEFAULT_EXPECTED_TS,
  parameter int          RECHECK_PERIOD = 1048576
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] req_addr,
  output logic [NUM_REQ-1:0] gnt,
  output logic               rsp_valid,
  output logic [2:0]         rsp_id,
  output logic [31:0]        rsp_data,
  output logic               sys_address,
  input  logic [31:0]        sys_readdata,
  output logic               boot_done,
  output logic               id_ok,
  output logic               id_fail
);

  localparam int IW = $clog2(NUM_REQ);

  sysid_state_t  state, state_nxt;
  logic [31:0]   id_q, ts_q;
  logic          run_en;
  logic          granted;
  logic [IW-1:0] win_idx;

  assign run_en = (state == RUN);

  midi_rr_arbiter #(.N(NUM_REQ)) u_arb (
    .clock   (clock),
    .reset   (reset),
    .req     (req),
    .enable  (run_en),
    .gnt     (gnt),
    .granted (granted),
    .winner  (win_idx)
  );

`ifdef MIDI_SYSID_RECHECK_EN
  localparam int CW = (RECHECK_PERIOD > 1) ? $clog2(RECHECK_PERIOD) : 1;

  logic [CW-1:0] recheck_cnt;
  logic          recheck_tick;

  // Counts RUN cycles only; the re-check reuses the boot read/compare states.
  assign recheck_tick = run_en && (recheck_cnt == CW'(RECHECK_PERIOD - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      recheck_cnt <= '0;
    end else if (run_en) begin
      recheck_cnt <= recheck_tick ? '0 : recheck_cnt + 1'b1;
    end
  end
`else
  logic unused_period;
  assign unused_period = ^RECHECK_PERIOD;
`endif

  always_comb begin
    state_nxt   = state;
    sys_address = SYSID_ADDR_ID;
    case (state)
      BOOT_ID: state_nxt = BOOT_TS;
      BOOT_TS: begin
        sys_address = SYSID_ADDR_TS;
        state_nxt   = CHECK;
      end
      CHECK:   state_nxt = RUN;
      RUN: begin
        if (granted) sys_address = req_addr[win_idx];
`ifdef MIDI_SYSID_RECHECK_EN
        if (recheck_tick) state_nxt = BOOT_ID;
`endif
      end
      default: state_nxt = BOOT_ID;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= BOOT_ID;
      id_q      <= '0;
      ts_q      <= '0;
      boot_done <= 1'b0;
      id_ok     <= 1'b0;
      id_fail   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
    end else begin
      state     <= state_nxt;
      rsp_valid <= granted;
      if (state == BOOT_ID) id_q <= sys_readdata;
      if (state == BOOT_TS) ts_q <= sys_readdata;
      if (state == CHECK) begin
        boot_done <= 1'b1;
        id_ok     <= (id_q == EXPECTED_ID) && (ts_q == EXPECTED_TS);
        id_fail   <= !((id_q == EXPECTED_ID) && (ts_q == EXPECTED_TS));
      end
      if (granted) begin
        rsp_id   <= 3'(win_idx);
        rsp_data <= sys_readdata;
      end
    end
  end

endmodule

`default_nettype wire
